recolector_bytes: RTL and testbench
===================================

// Module: recolector_bytes
// PURPOSE
//  Receive-side inverse of the lane-width converter: packs an 8-bit byte stream into
//  32/16/8-bit parallel words. The width is selected by PCLK/MODO with the same encoding
//  as the transmit side. Sits between the byte-wide PHY receive path and the parallel
//  PIPE-side data bus. Emits one word plus a one-cycle valid strobe per completed word.
// PARAMETERS
//  MSB_PRIMERO  1  1: first byte of a word lands in the top byte of the word (matches
//                  transmit order [31:24],[23:16],...); 0: first byte lands in [7:0].
// PORTS
//  clk        in   1   single clock; all state on posedge
//  reset_L    in   1   asynchronous, active-low reset
//  PCLK       in   2   width select: 00=32b, 01=16b, 10=8b, 11=8b (reserved)
//  MODO       in   1   1 forces 32-bit mode regardless of PCLK
//  in_8       in   8   received byte
//  valid_in   in   1   in_8 valid this cycle
//  out        out  32  assembled word, right-justified; unused upper bits = 0
//  valid_out  out  1   one-cycle strobe: out holds a new complete word
//  ocupado    out  1   1 while a word is partially assembled (count != 0)
// BEHAVIOUR
//  - Reset (reset_L=0, async): out=0, valid_out=0, ocupado=0, count=0, shift reg=0,
//    latched width = 8b. Reset mid-word discards the partial word; nothing is emitted.
//  - Width decode: MODO=1 or PCLK=00 -> 4 bytes; PCLK=01 -> 2; PCLK=10/11 -> 1.
//  - Width is latched only when a byte is accepted with count==0 (word start).
//    PCLK/MODO changes mid-word are ignored until the next word starts.
//  - FSM states: IDLE (count=0), ACUM (0<count<N). valid_in=0 -> hold state, no change.
//  - Accept (valid_in=1): byte -> shift reg; count++. When count reaches N-1 and a byte
//    is accepted: word complete, count->0, state->IDLE.
//  - Latency: out/valid_out are registered; valid_out=1 the cycle after the last byte
//    is accepted. out holds its value until the next completed word (not cleared).
//  - 8b mode: every accepted byte gives valid_out next cycle (back-to-back strobes).
//  - Back-to-back words: a byte accepted in the same cycle valid_out is high is legal
//    and starts the next word; no bubble is required.
//  - Packing, MSB_PRIMERO=1, 32b: bytes b0..b3 -> out={b0,b1,b2,b3}; 16b: out={16'h0,b0,b1};
//    8b: out={24'h0,b0}. MSB_PRIMERO=0 reverses the byte order within the active width.
//  - Gaps (valid_in=0 between bytes) are allowed in any number; no timeout.
//  - No backpressure: every byte offered with valid_in=1 is consumed.
// STRUCTURE
//  - Shared package/include: width codes (ANCHO_32=2'b00, ANCHO_16=2'b01, ANCHO_8=2'b10),
//    FSM state encodings (IDLE, ACUM). The transmit-side converter uses the same codes.
//  - One sub-module: decodificador_ancho (PCLK,MODO -> bytes-per-word 1/2/4), combinational
//    and shareable with the transmitter. Counter, shift register and output regs stay in top.
// TESTING
//  1 Reset: reset_L=0 mid-32b word after 2 bytes, release, send 4 bytes 11,22,33,44 ->
//    single valid_out, out=32'h11223344 (partial bytes discarded).
//  2 32b contiguous: MODO=1, bytes DE,AD,BE,EF,01,02,03,04 back-to-back -> valid_out at
//    cycles 5 and 9, out=DEADBEEF then 01020304.
//  3 16b with gaps: PCLK=01, bytes A5 (gap 3) 5A -> one strobe, out=32'h0000A55A.
//  4 8b stream: PCLK=10, bytes 01,02,03 contiguous -> three consecutive strobes,
//    out=00000001,00000002,00000003.
//  5 Width change mid-word: start 32b with AA,BB, switch PCLK=10, send CC,DD -> out=AABBCCDD;
//    next byte EE -> out=000000EE.
//  6 MSB_PRIMERO=0, 32b, bytes 11,22,33,44 -> out=32'h44332211; ocupado high cycles 2-4.

Source files
------------

// File: rtl/recolector_bytes_pkg.sv
// Shared codes for the byte packer and its transmit-side twin.
// Width-select encodings and FSM state encodings.
package recolector_bytes_pkg;

    localparam logic [1:0] ANCHO_32 = 2'b00;
    localparam logic [1:0] ANCHO_16 = 2'b01;
    localparam logic [1:0] ANCHO_8  = 2'b10;

    typedef enum logic {
        IDLE = 1'b0,
        ACUM = 1'b1
    } estado_t;

endpackage

// File: rtl/recolector_bytes_if.sv
// Byte-in / word-out bus of the receive packer.
// The master drives bytes and width select; the slave returns words.
interface recolector_bytes_if;

    logic [7:0]  in_8;
    logic        valid_in;
    logic [1:0]  PCLK;
    logic        MODO;
    logic [31:0] out;
    logic        valid_out;
    logic        ocupado;

    modport master (
        output in_8, valid_in, PCLK, MODO,
        input  out, valid_out, ocupado
    );

    modport slave (
        input  in_8, valid_in, PCLK, MODO,
        output out, valid_out, ocupado
    );

endinterface

// File: rtl/recolector_bytes_ancho.sv
// Width decoder: PCLK/MODO to bytes per word (1, 2 or 4).
// Purely combinational so the transmitter can reuse it.
module decodificador_ancho
    import recolector_bytes_pkg::*;
(
    input  logic [1:0] PCLK,
    input  logic       MODO,
    output logic [2:0] n_bytes
);

    always_comb begin
        n_bytes = 3'd1;
        unique case (1'b1)
            (MODO || PCLK == ANCHO_32):
                n_bytes = 3'd4;
            (!MODO && PCLK == ANCHO_16):
                n_bytes = 3'd2;
            default:
                n_bytes = 3'd1;
        endcase
    end

endmodule

// File: rtl/recolector_bytes.sv
// Packs a received byte stream into 32/16/8-bit words.
// Width is latched at word start; output is registered.
module recolector_bytes
    import recolector_bytes_pkg::*;
#(
    parameter bit MSB_PRIMERO = 1'b1
) (
    input logic               clk,
    input logic               reset_L,
    recolector_bytes_if.slave bus
);

    estado_t     st, st_n;
    logic [1:0]  cnt, cnt_n;
    logic [2:0]  n_dec, n_lat, n_lat_n, n_ef;
    logic [31:0] sr, sr_n, base;
    logic [31:0] out_q;
    logic        vo_q;
    logic        fin;

    decodificador_ancho u_dec (
        .PCLK    (bus.PCLK),
        .MODO    (bus.MODO),
        .n_bytes (n_dec)
    );

    // A new word uses the live width and a cleared
    // shift register so unused upper bytes read 0.
    always_comb begin
        st_n    = st;
        cnt_n   = cnt;
        n_lat_n = n_lat;
        sr_n    = sr;
        fin     = 1'b0;
        n_ef    = (cnt == 2'd0) ? n_dec : n_lat;
        base    = (cnt == 2'd0) ? '0 : sr;
        if (bus.valid_in) begin
            n_lat_n = n_ef;
            if (MSB_PRIMERO)
                sr_n = {base[23:0], bus.in_8};
            else
                sr_n = base |
                  ({24'h0, bus.in_8} << {cnt, 3'b000});
            if ({1'b0, cnt} == n_ef - 3'd1) begin
                fin   = 1'b1;
                cnt_n = 2'd0;
                st_n  = IDLE;
            end else begin
                cnt_n = cnt + 2'd1;
                st_n  = ACUM;
            end
        end
    end

    always_ff @(posedge clk or negedge reset_L) begin
        if (!reset_L) begin
            st    <= IDLE;
            cnt   <= 2'd0;
            n_lat <= 3'd1;
            sr    <= '0;
        end else begin
            st    <= st_n;
            cnt   <= cnt_n;
            n_lat <= n_lat_n;
            sr    <= sr_n;
        end
    end

    always_ff @(posedge clk or negedge reset_L) begin
        if (!reset_L) begin
            out_q <= '0;
            vo_q  <= 1'b0;
        end else begin
            vo_q <= fin;
            if (fin)
                out_q <= sr_n;
        end
    end

    assign bus.out       = out_q;
    assign bus.valid_out = vo_q;
    assign bus.ocupado   = (st == ACUM);

endmodule

// File: tb/tb_recolector_bytes.sv
// Directed bench for recolector_bytes.
// Two instances: MSB-first (a) and LSB-first (b).
module tb_recolector_bytes;

    logic clk = 1'b0;
    logic reset_L = 1'b0;
    int   n_chk = 0;
    int   n_err = 0;

    always #5 clk = ~clk;

    recolector_bytes_if ia ();
    recolector_bytes_if ib ();

    recolector_bytes #(.MSB_PRIMERO(1'b1)) dut_a (
        .clk     (clk),
        .reset_L (reset_L),
        .bus     (ia.slave)
    );

    recolector_bytes #(.MSB_PRIMERO(1'b0)) dut_b (
        .clk     (clk),
        .reset_L (reset_L),
        .bus     (ib.slave)
    );

    task automatic chk(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h",
                     tag, got, exp);
        end
    endtask

    task automatic set_w(input logic [1:0] p,
                         input logic m);
        ia.PCLK = p;
        ia.MODO = m;
        ib.PCLK = p;
        ib.MODO = m;
    endtask

    // Inputs change 1 time unit after posedge and
    // outputs are sampled at the same point.
    task automatic step(input logic v,
                        input logic [7:0] b);
        ia.valid_in = v;
        ia.in_8     = b;
        ib.valid_in = v;
        ib.in_8     = b;
        @(posedge clk);
        #1;
    endtask

    task automatic push_a(input string tag,
                          input logic [7:0] b,
                          input logic vo,
                          input logic [31:0] o);
        step(1'b1, b);
        chk({tag, ".vo"}, {31'h0, ia.valid_out},
            {31'h0, vo});
        if (vo)
            chk({tag, ".out"}, ia.out, o);
    endtask

    initial begin
        set_w(2'b00, 1'b1);
        ia.valid_in = 1'b0;
        ia.in_8     = 8'h00;
        ib.valid_in = 1'b0;
        ib.in_8     = 8'h00;
        #1;
        chk("rst.out", ia.out, 32'h0);
        chk("rst.vo", {31'h0, ia.valid_out}, 32'h0);
        chk("rst.ocu", {31'h0, ia.ocupado}, 32'h0);
        @(posedge clk);
        #1;
        reset_L = 1'b1;

        // 1: reset in the middle of a 32-bit word
        step(1'b1, 8'h77);
        step(1'b1, 8'h88);
        chk("t1.ocu", {31'h0, ia.ocupado}, 32'h1);
        reset_L = 1'b0;
        #1;
        chk("t1.rocu", {31'h0, ia.ocupado}, 32'h0);
        chk("t1.rvo", {31'h0, ia.valid_out}, 32'h0);
        step(1'b0, 8'h00);
        reset_L = 1'b1;
        step(1'b0, 8'h00);
        chk("t1.idle", {31'h0, ia.valid_out}, 32'h0);
        push_a("t1.b0", 8'h11, 1'b0, 32'h0);
        push_a("t1.b1", 8'h22, 1'b0, 32'h0);
        push_a("t1.b2", 8'h33, 1'b0, 32'h0);
        push_a("t1.b3", 8'h44, 1'b1, 32'h11223344);
        step(1'b0, 8'h00);
        chk("t1.once", {31'h0, ia.valid_out}, 32'h0);

        // 2: 32-bit back-to-back words
        push_a("t2.b0", 8'hDE, 1'b0, 32'h0);
        push_a("t2.b1", 8'hAD, 1'b0, 32'h0);
        push_a("t2.b2", 8'hBE, 1'b0, 32'h0);
        push_a("t2.b3", 8'hEF, 1'b1, 32'hDEADBEEF);
        push_a("t2.b4", 8'h01, 1'b0, 32'h0);
        push_a("t2.b5", 8'h02, 1'b0, 32'h0);
        push_a("t2.b6", 8'h03, 1'b0, 32'h0);
        push_a("t2.b7", 8'h04, 1'b1, 32'h01020304);

        // 3: 16-bit word with a gap
        set_w(2'b01, 1'b0);
        push_a("t3.b0", 8'hA5, 1'b0, 32'h0);
        for (int i = 0; i < 3; i++) begin
            step(1'b0, 8'hFF);
            chk("t3.gvo", {31'h0, ia.valid_out}, 32'h0);
            chk("t3.gocu", {31'h0, ia.ocupado}, 32'h1);
        end
        push_a("t3.b1", 8'h5A, 1'b1, 32'h0000A55A);
        step(1'b0, 8'h00);
        chk("t3.hold", ia.out, 32'h0000A55A);

        // 4: 8-bit stream
        set_w(2'b10, 1'b0);
        push_a("t4.b0", 8'h01, 1'b1, 32'h00000001);
        push_a("t4.b1", 8'h02, 1'b1, 32'h00000002);
        push_a("t4.b2", 8'h03, 1'b1, 32'h00000003);
        step(1'b0, 8'h00);
        chk("t4.end", {31'h0, ia.valid_out}, 32'h0);

        // 5: width change is ignored mid-word
        set_w(2'b00, 1'b0);
        push_a("t5.b0", 8'hAA, 1'b0, 32'h0);
        push_a("t5.b1", 8'hBB, 1'b0, 32'h0);
        set_w(2'b10, 1'b0);
        push_a("t5.b2", 8'hCC, 1'b0, 32'h0);
        push_a("t5.b3", 8'hDD, 1'b1, 32'hAABBCCDD);
        push_a("t5.b4", 8'hEE, 1'b1, 32'h000000EE);

        // 6: LSB-first packing on instance b
        set_w(2'b11, 1'b1);
        step(1'b0, 8'h00);
        chk("t6.pre", {31'h0, ib.ocupado}, 32'h0);
        step(1'b1, 8'h11);
        chk("t6.ocu1", {31'h0, ib.ocupado}, 32'h1);
        step(1'b1, 8'h22);
        chk("t6.ocu2", {31'h0, ib.ocupado}, 32'h1);
        step(1'b1, 8'h33);
        chk("t6.ocu3", {31'h0, ib.ocupado}, 32'h1);
        chk("t6.vo3", {31'h0, ib.valid_out}, 32'h0);
        step(1'b1, 8'h44);
        chk("t6.ocu4", {31'h0, ib.ocupado}, 32'h0);
        chk("t6.vo", {31'h0, ib.valid_out}, 32'h1);
        chk("t6.out", ib.out, 32'h44332211);
        chk("t6.outa", ia.out, 32'h11223344);
        step(1'b0, 8'h00);
        chk("t6.end", {31'h0, ib.valid_out}, 32'h0);

        $display("Simulation finished: %0d checks, %0d errors",
                 n_chk, n_err);
        $finish;
    end

endmodule
